// File: rtl/alu_seq64_pkg.sv
// Shared ALU definitions: op codes, default data width and the op mapping used
// by requesters that sequence wide operations over one 32-bit ALU.
package alu_seq64_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Compares are done as a subtraction; everything else maps 1:1.
  function automatic logic [2:0] seq_pass_op(input logic [2:0] op);
    return (op == ALU_SUB || op == ALU_SLT || op == ALU_SLTU) ? ALU_SUB : op;
  endfunction

endpackage

// File: rtl/alu_seq64.sv
// Sequences 64-bit ops over a shared 32-bit ALU in 2-3 passes (LO, HI, optional FIX).
// Optional: define ALU_SEQ_SLT64_EN to enable signed 64-bit compare (op 010).
module alu_seq64
  import alu_seq64_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_op,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_WIDTH-1:0]   rsp_result,
  output logic                      rsp_overflow,
  output logic                      rsp_zero,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [2:0]                alu_op,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_carryout
);

  localparam int DW = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

`ifdef ALU_SEQ_SLT64_EN
  localparam bit SLT64_EN = 1'b1;
`else
  localparam bit SLT64_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [W2-1:0]   a_q, b_q;
  logic [DW-1:0]   res_lo, res_hi;
  logic            c0, c1, c2;
  logic            rsp_valid_q;
  logic            arith;
  logic            a63, b63, r63, ovf_add, ovf_sub;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = rsp_valid_q;

  // Ops whose high half needs the low-half carry/borrow folded in by FIX.
  assign arith = (op_q == ALU_ADD) || (op_q == ALU_SUB) || (op_q == ALU_SLTU) ||
                 (SLT64_EN && op_q == ALU_SLT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_lo      <= '0;
      res_hi      <= '0;
      c0          <= 1'b0;
      c1          <= 1'b0;
      c2          <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
          c2   <= 1'b0;
          if (req_op == ALU_SLT && !SLT64_EN) begin
            state       <= S_DONE;
            rsp_valid_q <= 1'b1;
          end else begin
            state <= S_LO;
          end
        end
        S_LO: begin
          res_lo <= alu_result;
          c0     <= alu_carryout;
          state  <= S_HI;
        end
        S_HI: begin
          res_hi <= alu_result;
          c1     <= alu_carryout;
          if (arith && c0) begin
            state <= S_FIX;
          end else begin
            state       <= S_DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        S_FIX: begin
          res_hi      <= alu_result;
          c2          <= alu_carryout;
          state       <= S_DONE;
          rsp_valid_q <= 1'b1;
        end
        S_DONE: if (rsp_ready) begin
          state       <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state)
      S_LO: begin
        alu_a  = a_q[DW-1:0];
        alu_b  = b_q[DW-1:0];
        alu_op = seq_pass_op(op_q);
      end
      S_HI: begin
        alu_a  = a_q[W2-1:DW];
        alu_b  = b_q[W2-1:DW];
        alu_op = seq_pass_op(op_q);
      end
      S_FIX: begin
        alu_a  = res_hi;
        alu_b  = {{(DW-1){1'b0}}, 1'b1};
        alu_op = (op_q == ALU_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  // Overflow from latched operand signs and the final result sign.
  assign a63     = a_q[W2-1];
  assign b63     = b_q[W2-1];
  assign r63     = res_hi[DW-1];
  assign ovf_add = ~(a63 ^ b63) & (a63 ^ r63);
  assign ovf_sub =  (a63 ^ b63) & (a63 ^ r63);

  always_comb begin
    rsp_result   = {res_hi, res_lo};
    rsp_overflow = 1'b0;
    case (op_q)
      ALU_ADD:  rsp_overflow = ovf_add;
      ALU_SUB:  rsp_overflow = ovf_sub;
      ALU_SLTU: rsp_result   = {{(W2-1){1'b0}}, c1 | c2};
      ALU_SLT:  rsp_result   = SLT64_EN ? {{(W2-1){1'b0}}, r63 ^ ovf_sub} : '0;
      default: ;
    endcase
  end

  assign rsp_zero = (rsp_result == '0);

endmodule
